// File: rtl/pipe_mem_wb_stage_pkg.sv
// Shared configuration for the MEM/WB writeback slice: widths and result-source encodings.
// No logic; constants and types only.
// No flow control.
package pipe_mem_wb_stage_pkg;

  localparam int CFG_XLEN      = 32;
  localparam int CFG_RF_ADDR_W = 5;
  localparam int CFG_CNT_W     = 64;

  // Which memory-stage value becomes the writeback result
  typedef enum logic {
    RES_MUX = 1'b0,
    RES_MEM = 1'b1
  } result_src_e;

  // x0 is hardwired to zero, so it is never a legal write target
  function automatic logic rd_writable(input logic [CFG_RF_ADDR_W-1:0] rd);
    return rd != '0;
  endfunction

endpackage

// File: rtl/riscv_instret_counter.sv
// Free-running event counter (minstret/mcycle style) with CSR overwrite.
// Updates one cycle after the event or write is presented.
// A CSR write in the same cycle as an event wins; that event is not counted.
module riscv_instret_counter #(
  parameter int CNT_W = 64
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_inc,
  input  logic             i_we,
  input  logic [CNT_W-1:0] i_wdata,
  output logic [CNT_W-1:0] o_cnt
);

  // CSR write first, then increment with natural wrap at all-ones
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_cnt <= '0;
    end else if (i_we) begin
      o_cnt <= i_wdata;
    end else if (i_inc) begin
      o_cnt <= o_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/riscv_mux.sv
// Generic N:1 word mux selected by a binary index.
// Purely combinational, zero latency.
// No flow control.
module riscv_mux #(
  parameter int N_MUX_IN = 2,
  parameter int W        = 32,
  parameter int SEL_W    = (N_MUX_IN > 1) ? $clog2(N_MUX_IN) : 1
) (
  input  logic [N_MUX_IN-1:0][W-1:0] i_in,
  input  logic [SEL_W-1:0]           i_sel,
  output logic [W-1:0]               o_out
);

  assign o_out = i_in[i_sel];

endmodule

// File: rtl/pipe_mem_wb_stage.sv
// MEM/WB pipeline register, writeback select, rf write qualify and retired-instruction count.
// One cycle from M inputs to W outputs; result mux is combinational off the register.
// Stall holds every WB register; flush clears valid/regwrite and overrides stall.
module pipe_mem_wb_stage
  import pipe_mem_wb_stage_pkg::*;
#(
  parameter int XLEN      = CFG_XLEN,
  parameter int RF_ADDR_W = CFG_RF_ADDR_W,
  parameter int CNT_W     = CFG_CNT_W
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic [XLEN-1:0]      i_dp_dmem_RD,
  input  logic [XLEN-1:0]      i_dp_4to1muxM,
  input  logic                 i_ResultSrcM,
  input  logic                 i_RegWriteM,
  input  logic [RF_ADDR_W-1:0] i_RdM,
  input  logic                 i_validM,
  input  logic                 i_stallW,
  input  logic                 i_flushW,
  input  logic                 i_instret_we,
  input  logic [CNT_W-1:0]     i_instret_wdata,
  output logic [XLEN-1:0]      o_dp_ResultW,
  output logic [RF_ADDR_W-1:0] o_RdW,
  output logic                 o_RegWriteW,
  output logic                 o_validW,
  output logic [CNT_W-1:0]     o_instret
);

  logic                 valid_q;
  logic                 regwrite_q;
  result_src_e          result_src_q;
  logic [RF_ADDR_W-1:0] rd_q;
  logic [XLEN-1:0]      dmem_q;
  logic [XLEN-1:0]      mux_q;

  logic                 retire;
  logic [1:0][XLEN-1:0] wb_mux_in;
  logic                 wb_sel;

  // WB register: flush kills the instruction (data fields left as-is), stall freezes, else capture M
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      valid_q      <= 1'b0;
      regwrite_q   <= 1'b0;
      result_src_q <= RES_MUX;
      rd_q         <= '0;
      dmem_q       <= '0;
      mux_q        <= '0;
    end else if (i_flushW) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
    end else if (!i_stallW) begin
      valid_q      <= i_validM;
      regwrite_q   <= i_RegWriteM;
      result_src_q <= result_src_e'(i_ResultSrcM);
      rd_q         <= i_RdM;
      dmem_q       <= i_dp_dmem_RD;
      mux_q        <= i_dp_4to1muxM;
    end
  end

  // Index 1 is load data, index 0 the memory-stage mux result
  assign wb_mux_in = {dmem_q, mux_q};
  assign wb_sel    = (result_src_q == RES_MEM);

  riscv_mux #(
    .N_MUX_IN (2),
    .W        (XLEN)
  ) u_wb_mux (
    .i_in  (wb_mux_in),
    .i_sel (wb_sel),
    .o_out (o_dp_ResultW)
  );

  // Bubbles and x0 targets never reach the register file
  assign o_RegWriteW = regwrite_q & valid_q & rd_writable(CFG_RF_ADDR_W'(rd_q));
  assign o_RdW       = rd_q;
  assign o_validW    = valid_q;

  // An instruction retires on the edge it leaves WB, so a long stall counts once
  assign retire = valid_q & ~i_stallW & ~i_flushW;

  riscv_instret_counter #(
    .CNT_W (CNT_W)
  ) u_instret (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_inc   (retire),
    .i_we    (i_instret_we),
    .i_wdata (i_instret_wdata),
    .o_cnt   (o_instret)
  );

endmodule

// File: tb/tb_pipe_mem_wb_stage.sv
// Bench for the MEM/WB writeback stage: directed vector table, reset corner, random vs model.
// Inputs change #1 after the rising edge; outputs are sampled at that same point.
// Summary line reports comparisons made and failed.
module tb_pipe_mem_wb_stage;

  localparam logic O = 1'b0;
  localparam logic I = 1'b1;

  logic        i_clk = 1'b0;
  logic        i_rstn;
  logic [31:0] i_dp_dmem_RD;
  logic [31:0] i_dp_4to1muxM;
  logic        i_ResultSrcM;
  logic        i_RegWriteM;
  logic [4:0]  i_RdM;
  logic        i_validM;
  logic        i_stallW;
  logic        i_flushW;
  logic        i_instret_we;
  logic [63:0] i_instret_wdata;
  logic [31:0] o_dp_ResultW;
  logic [4:0]  o_RdW;
  logic        o_RegWriteW;
  logic        o_validW;
  logic [63:0] o_instret;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_mem_wb_stage dut (
    .i_clk           (i_clk),
    .i_rstn          (i_rstn),
    .i_dp_dmem_RD    (i_dp_dmem_RD),
    .i_dp_4to1muxM   (i_dp_4to1muxM),
    .i_ResultSrcM    (i_ResultSrcM),
    .i_RegWriteM     (i_RegWriteM),
    .i_RdM           (i_RdM),
    .i_validM        (i_validM),
    .i_stallW        (i_stallW),
    .i_flushW        (i_flushW),
    .i_instret_we    (i_instret_we),
    .i_instret_wdata (i_instret_wdata),
    .o_dp_ResultW    (o_dp_ResultW),
    .o_RdW           (o_RdW),
    .o_RegWriteW     (o_RegWriteW),
    .o_validW        (o_validW),
    .o_instret       (o_instret)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        stall, flush, we;
    logic [63:0] wdata;
    logic        src;
    logic [31:0] rd_dat, mux_dat;
    logic        rw;
    logic [4:0]  rd;
    logic        v;
    logic        e_v, e_rw;
    logic [4:0]  e_rd;
    logic [31:0] e_res;
    logic        chk_data;
    logic [63:0] e_cnt;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic stall, input logic flush, input logic we, input logic [63:0] wdata,
                       input logic src, input logic [31:0] rd_dat, input logic [31:0] mux_dat,
                       input logic rw, input logic [4:0] rd, input logic v);
    i_stallW        = stall;
    i_flushW        = flush;
    i_instret_we    = we;
    i_instret_wdata = wdata;
    i_ResultSrcM    = src;
    i_dp_dmem_RD    = rd_dat;
    i_dp_4to1muxM   = mux_dat;
    i_RegWriteM     = rw;
    i_RdM           = rd;
    i_validM        = v;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"},   64'(o_validW),     64'd0);
    check({tag, "_regwr"},   64'(o_RegWriteW),  64'd0);
    check({tag, "_result"},  64'(o_dp_ResultW), 64'd0);
    check({tag, "_rd"},      64'(o_RdW),        64'd0);
    check({tag, "_instret"}, o_instret,         64'd0);
  endtask

  // Reference model state: what WB holds, expressed as the final writeback value
  logic        m_v, m_rw, m_known;
  logic [4:0]  m_rd;
  logic [31:0] m_res;
  logic [63:0] m_cnt;

  initial begin
    // Directed vectors: inputs for one cycle and W outputs expected after that edge
    vecs[0]  = '{O,O,O,64'h0,I,32'hDEADBEEF,32'h00001234,I,5'd5,I, I,I,5'd5,32'hDEADBEEF,I,64'd0};
    vecs[1]  = '{O,O,O,64'h0,O,32'h0,32'h00005555,I,5'd0,I, I,O,5'd0,32'h00005555,I,64'd1};
    vecs[2]  = '{O,O,O,64'h0,I,32'hAAAA0001,32'h0,I,5'd7,I, I,I,5'd7,32'hAAAA0001,I,64'd2};
    vecs[3]  = '{I,O,O,64'h0,O,32'h0,32'h00001111,I,5'd9,I, I,I,5'd7,32'hAAAA0001,I,64'd2};
    vecs[4]  = '{I,O,O,64'h0,O,32'h0,32'h00001111,I,5'd9,I, I,I,5'd7,32'hAAAA0001,I,64'd2};
    vecs[5]  = '{I,O,O,64'h0,O,32'h0,32'h00001111,I,5'd9,I, I,I,5'd7,32'hAAAA0001,I,64'd2};
    vecs[6]  = '{O,O,O,64'h0,O,32'h0,32'h00002222,I,5'd3,I, I,I,5'd3,32'h00002222,I,64'd3};
    vecs[7]  = '{I,I,O,64'h0,O,32'h0,32'h00003333,I,5'd4,I, O,O,5'd0,32'h0,O,64'd3};
    vecs[8]  = '{O,O,O,64'h0,O,32'h0,32'h00004444,I,5'd6,O, O,O,5'd6,32'h00004444,I,64'd3};
    vecs[9]  = '{O,O,I,64'hFFFF_FFFF_FFFF_FFFF,O,32'h0,32'h00000077,I,5'd1,I,
                 I,I,5'd1,32'h00000077,I,64'hFFFF_FFFF_FFFF_FFFF};
    vecs[10] = '{O,O,O,64'h0,O,32'h0,32'h0,O,5'd0,O, O,O,5'd0,32'h0,I,64'd0};
    vecs[11] = '{O,O,O,64'h0,O,32'h0,32'h00000088,I,5'd2,I, I,I,5'd2,32'h00000088,I,64'd0};
    vecs[12] = '{O,O,I,64'h100,O,32'h0,32'h0,O,5'd0,O, O,O,5'd0,32'h0,I,64'h100};
    vecs[13] = '{O,O,O,64'h0,O,32'h0,32'h0,O,5'd0,O, O,O,5'd0,32'h0,I,64'h100};

    // Reset and idle
    i_rstn = 1'b0;
    drive(O, O, O, 64'h0, O, 32'h0, 32'h0, O, 5'd0, O);
    tick();
    tick();
    check_all_zero("in_reset");
    i_rstn = 1'b1;
    tick();
    check_all_zero("after_reset");

    // Directed table
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].stall, vecs[i].flush, vecs[i].we, vecs[i].wdata, vecs[i].src,
            vecs[i].rd_dat, vecs[i].mux_dat, vecs[i].rw, vecs[i].rd, vecs[i].v);
      tick();
      check($sformatf("vec%0d_valid", i), 64'(o_validW), 64'(vecs[i].e_v));
      check($sformatf("vec%0d_regwr", i), 64'(o_RegWriteW), 64'(vecs[i].e_rw));
      check($sformatf("vec%0d_instret", i), o_instret, vecs[i].e_cnt);
      if (vecs[i].chk_data) begin
        check($sformatf("vec%0d_rd", i), 64'(o_RdW), 64'(vecs[i].e_rd));
        check($sformatf("vec%0d_result", i), 64'(o_dp_ResultW), 64'(vecs[i].e_res));
      end
    end

    // Reset arriving in the middle of a stall clears everything at once
    drive(O, O, O, 64'h0, I, 32'hCAFEF00D, 32'h0, I, 5'd11, I);
    tick();
    check("mid_stall_pre_valid", 64'(o_validW), 64'd1);
    drive(I, O, O, 64'h0, O, 32'h0, 32'h0, I, 5'd12, I);
    #2;
    i_rstn = 1'b0;
    #1;
    check_all_zero("async_reset");
    tick();
    i_rstn = 1'b1;
    tick();
    check_all_zero("post_reset_stalled");
    drive(O, O, O, 64'h0, O, 32'h0, 32'h0, O, 5'd0, O);
    tick();
    check_all_zero("post_reset_idle");

    // Random traffic against the model; WB currently holds a reset-clean bubble
    m_v = 1'b0; m_rw = 1'b0; m_rd = 5'd0; m_res = 32'h0; m_cnt = 64'd0; m_known = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      logic        stall, flush, we, src, rw, v, retire;
      logic [63:0] wdata;
      logic [31:0] rd_dat, mux_dat;
      logic [4:0]  rd;
      stall   = ($urandom_range(0, 3) == 0);
      flush   = ($urandom_range(0, 9) == 0);
      we      = ($urandom_range(0, 39) == 0);
      wdata   = ($urandom_range(0, 1) == 0) ? 64'hFFFF_FFFF_FFFF_FFFD : {32'($urandom), 32'($urandom)};
      src     = 1'($urandom_range(0, 1));
      rw      = ($urandom_range(0, 3) != 0);
      v       = ($urandom_range(0, 4) != 0);
      rd      = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      rd_dat  = 32'($urandom);
      mux_dat = 32'($urandom);
      drive(stall, flush, we, wdata, src, rd_dat, mux_dat, rw, rd, v);

      retire = m_v && !stall && !flush;
      if (we) m_cnt = wdata;
      else if (retire) m_cnt = m_cnt + 64'd1;
      if (flush) begin
        m_v = 1'b0; m_rw = 1'b0; m_known = 1'b0;
      end else if (!stall) begin
        m_v = v; m_rw = rw; m_rd = rd; m_res = src ? rd_dat : mux_dat; m_known = 1'b1;
      end

      tick();
      check($sformatf("rnd%0d_valid", c), 64'(o_validW), 64'(m_v));
      check($sformatf("rnd%0d_regwr", c), 64'(o_RegWriteW), 64'(m_v && m_rw && (m_rd != 5'd0)));
      check($sformatf("rnd%0d_instret", c), o_instret, m_cnt);
      if (m_known) begin
        check($sformatf("rnd%0d_rd", c), 64'(o_RdW), 64'(m_rd));
        check($sformatf("rnd%0d_result", c), 64'(o_dp_ResultW), 64'(m_res));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
